// File: rtl/raster_pkg.sv
// Shared types and widths for the tiled triangle rasteriser.
package raster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Two guard bits above the product width keep edge sums from wrapping.
    localparam int EDGE_GUARD_BITS = 2;

    function automatic int edge_w(input int vertex_width);
        return 2 * vertex_width + EDGE_GUARD_BITS;
    endfunction

endpackage

// File: rtl/tri_setup.sv
// Triangle setup: bbox clipped to the tile, edge start values, per-axis edge
// increments, signed area and framebuffer address stepping.
module tri_setup
    import raster_pkg::*;
#(
    parameter int VERTEX_WIDTH  = 12,
    parameter int FB_ADDR_WIDTH = 17,
    parameter int FB_WIDTH      = 320,
    parameter int TILE_MIN_X    = 0,
    parameter int TILE_MAX_X    = 319,
    parameter int TILE_MIN_Y    = 0,
    parameter int TILE_MAX_Y    = 239,
    localparam int EW           = edge_w(VERTEX_WIDTH)
) (
    input  logic signed [VERTEX_WIDTH-1:0]  x0,
    input  logic signed [VERTEX_WIDTH-1:0]  y0,
    input  logic signed [VERTEX_WIDTH-1:0]  x1,
    input  logic signed [VERTEX_WIDTH-1:0]  y1,
    input  logic signed [VERTEX_WIDTH-1:0]  x2,
    input  logic signed [VERTEX_WIDTH-1:0]  y2,
    output logic signed [VERTEX_WIDTH-1:0]  min_x,
    output logic signed [VERTEX_WIDTH-1:0]  min_y,
    output logic signed [VERTEX_WIDTH-1:0]  max_x,
    output logic signed [VERTEX_WIDTH-1:0]  max_y,
    output logic                            empty,
    output logic signed [EW-1:0]            area,
    output logic signed [EW-1:0]            e_start [3],
    output logic signed [EW-1:0]            dx [3],
    output logic signed [EW-1:0]            dy [3],
    output logic [FB_ADDR_WIDTH-1:0]        addr_start,
    output logic [FB_ADDR_WIDTH-1:0]        row_step
);

    localparam int VW  = VERTEX_WIDTH;
    localparam int FAW = FB_ADDR_WIDTH;

    localparam logic signed [VW-1:0] TMIN_X = VW'(TILE_MIN_X);
    localparam logic signed [VW-1:0] TMAX_X = VW'(TILE_MAX_X);
    localparam logic signed [VW-1:0] TMIN_Y = VW'(TILE_MIN_Y);
    localparam logic signed [VW-1:0] TMAX_Y = VW'(TILE_MAX_Y);

    function automatic logic signed [VW-1:0] min3(input logic signed [VW-1:0] a,
                                                  input logic signed [VW-1:0] b,
                                                  input logic signed [VW-1:0] c);
        logic signed [VW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [VW-1:0] max3(input logic signed [VW-1:0] a,
                                                  input logic signed [VW-1:0] b,
                                                  input logic signed [VW-1:0] c);
        logic signed [VW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // E(x,y) = (x-xa)*(yb-ya) - (y-ya)*(xb-xa)
    function automatic logic signed [EW-1:0] edge_eval(input logic signed [VW-1:0] px,
                                                       input logic signed [VW-1:0] py,
                                                       input logic signed [VW-1:0] xa,
                                                       input logic signed [VW-1:0] ya,
                                                       input logic signed [VW-1:0] xb,
                                                       input logic signed [VW-1:0] yb);
        logic signed [EW-1:0] ox, oy, sx, sy;
        ox = EW'(px) - EW'(xa);
        oy = EW'(py) - EW'(ya);
        sx = EW'(xb) - EW'(xa);
        sy = EW'(yb) - EW'(ya);
        return ox * sy - oy * sx;
    endfunction

    logic signed [VW-1:0] lo_x, hi_x, lo_y, hi_y;

    always_comb begin
        lo_x  = min3(x0, x1, x2);
        hi_x  = max3(x0, x1, x2);
        lo_y  = min3(y0, y1, y2);
        hi_y  = max3(y0, y1, y2);
        min_x = (lo_x < TMIN_X) ? TMIN_X : lo_x;
        max_x = (hi_x > TMAX_X) ? TMAX_X : hi_x;
        min_y = (lo_y < TMIN_Y) ? TMIN_Y : lo_y;
        max_y = (hi_y > TMAX_Y) ? TMAX_Y : hi_y;
        empty = (min_x > max_x) || (min_y > max_y);

        area       = edge_eval(x2, y2, x0, y0, x1, y1);
        e_start[0] = edge_eval(min_x, min_y, x0, y0, x1, y1);
        e_start[1] = edge_eval(min_x, min_y, x1, y1, x2, y2);
        e_start[2] = edge_eval(min_x, min_y, x2, y2, x0, y0);

        // dE/dx = yb-ya, dE/dy = -(xb-xa)
        dx[0] = EW'(y1) - EW'(y0);
        dy[0] = EW'(x0) - EW'(x1);
        dx[1] = EW'(y2) - EW'(y1);
        dy[1] = EW'(x1) - EW'(x2);
        dx[2] = EW'(y0) - EW'(y2);
        dy[2] = EW'(x2) - EW'(x0);

        addr_start = FAW'($unsigned(min_y)) * FAW'(FB_WIDTH) + FAW'($unsigned(min_x));
        row_step   = FAW'(FB_WIDTH) - FAW'($unsigned(max_x - min_x));
    end

endmodule

// File: rtl/tiled_rasterizer.sv
// Scan-converts one triangle at a time over its tile-clipped bounding box,
// emitting covered pixels on a ready/valid fragment stream.
module tiled_rasterizer
    import raster_pkg::*;
#(
    parameter int VERTEX_WIDTH  = 12,
    parameter int FB_ADDR_WIDTH = 17,
    parameter int FB_WIDTH      = 320,
    parameter int FB_HEIGHT     = 240,
    parameter int TILE_MIN_X    = 0,
    parameter int TILE_MAX_X    = FB_WIDTH - 1,
    parameter int TILE_MIN_Y    = 0,
    parameter int TILE_MAX_Y    = FB_HEIGHT - 1,
    parameter int CULL_BACK     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [VERTEX_WIDTH-1:0]   x0,
    input  logic signed [VERTEX_WIDTH-1:0]   y0,
    input  logic signed [VERTEX_WIDTH-1:0]   x1,
    input  logic signed [VERTEX_WIDTH-1:0]   y1,
    input  logic signed [VERTEX_WIDTH-1:0]   x2,
    input  logic signed [VERTEX_WIDTH-1:0]   y2,
    input  logic                             start,
    output logic                             ready,
    output logic                             frag_valid,
    input  logic                             frag_ready,
    output logic signed [VERTEX_WIDTH-1:0]   frag_x,
    output logic signed [VERTEX_WIDTH-1:0]   frag_y,
    output logic [FB_ADDR_WIDTH-1:0]         frag_addr,
    output logic                             done
);

    localparam int VW  = VERTEX_WIDTH;
    localparam int FAW = FB_ADDR_WIDTH;
    localparam int EW  = edge_w(VERTEX_WIDTH);

    state_t state, state_nxt;

    logic signed [VW-1:0]  v_x0, v_y0, v_x1, v_y1, v_x2, v_y2;
    logic signed [VW-1:0]  s_min_x, s_min_y, s_max_x, s_max_y;
    logic                  s_empty, skip;
    logic signed [EW-1:0]  s_area;
    logic signed [EW-1:0]  s_e_start [3];
    logic signed [EW-1:0]  s_dx [3];
    logic signed [EW-1:0]  s_dy [3];
    logic [FAW-1:0]        s_addr_start, s_row_step;

    logic signed [VW-1:0]  x_p0, y_p0, min_x_r, max_x_r, max_y_r;
    logic [FAW-1:0]        addr_p0, row_step_r;
    logic signed [EW-1:0]  e_p0 [3];
    logic signed [EW-1:0]  row_e [3];
    logic signed [EW-1:0]  dx_r [3];
    logic signed [EW-1:0]  dy_r [3];
    logic                  area_neg, scan_done;
    logic                  eol_p0, last_p0, pos_p0, neg_p0, covered_p0, advance;

    logic                  vld_p1;
    logic signed [VW-1:0]  x_p1, y_p1;
    logic [FAW-1:0]        addr_p1;

    tri_setup #(
        .VERTEX_WIDTH (VERTEX_WIDTH),
        .FB_ADDR_WIDTH(FB_ADDR_WIDTH),
        .FB_WIDTH     (FB_WIDTH),
        .TILE_MIN_X   (TILE_MIN_X),
        .TILE_MAX_X   (TILE_MAX_X),
        .TILE_MIN_Y   (TILE_MIN_Y),
        .TILE_MAX_Y   (TILE_MAX_Y)
    ) u_setup (
        .x0        (v_x0),
        .y0        (v_y0),
        .x1        (v_x1),
        .y1        (v_y1),
        .x2        (v_x2),
        .y2        (v_y2),
        .min_x     (s_min_x),
        .min_y     (s_min_y),
        .max_x     (s_max_x),
        .max_y     (s_max_y),
        .empty     (s_empty),
        .area      (s_area),
        .e_start   (s_e_start),
        .dx        (s_dx),
        .dy        (s_dy),
        .addr_start(s_addr_start),
        .row_step  (s_row_step)
    );

    assign skip = s_empty || (s_area == '0) || (s_area[EW-1] && (CULL_BACK != 0));

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = skip ? ST_DONE : ST_SCAN;
            ST_SCAN:  if (scan_done && (!vld_p1 || frag_ready)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
        done  = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (start && ready) begin
            v_x0 <= x0;
            v_y0 <= y0;
            v_x1 <= x1;
            v_y1 <= y1;
            v_x2 <= x2;
            v_y2 <= y2;
        end
    end

    // Stage p0: evaluate the current pixel; stall while the output is blocked.
    always_comb begin
        eol_p0     = (x_p0 == max_x_r);
        last_p0    = eol_p0 && (y_p0 == max_y_r);
        pos_p0     = !e_p0[0][EW-1] && !e_p0[1][EW-1] && !e_p0[2][EW-1];
        neg_p0     = (e_p0[0][EW-1] || e_p0[0] == '0) &&
                     (e_p0[1][EW-1] || e_p0[1] == '0) &&
                     (e_p0[2][EW-1] || e_p0[2] == '0);
        covered_p0 = area_neg ? neg_p0 : pos_p0;
        advance    = (state == ST_SCAN) && !scan_done && (!vld_p1 || frag_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst)                    scan_done <= 1'b0;
        else if (state == ST_SETUP)  scan_done <= 1'b0;
        else if (advance && last_p0) scan_done <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (state == ST_SETUP) begin
            x_p0       <= s_min_x;
            y_p0       <= s_min_y;
            addr_p0    <= s_addr_start;
            min_x_r    <= s_min_x;
            max_x_r    <= s_max_x;
            max_y_r    <= s_max_y;
            row_step_r <= s_row_step;
            area_neg   <= s_area[EW-1];
            for (int i = 0; i < 3; i++) begin
                e_p0[i]  <= s_e_start[i];
                row_e[i] <= s_e_start[i];
                dx_r[i]  <= s_dx[i];
                dy_r[i]  <= s_dy[i];
            end
        end else if (advance && !last_p0) begin
            if (eol_p0) begin
                x_p0    <= min_x_r;
                y_p0    <= y_p0 + VW'(1);
                addr_p0 <= addr_p0 + row_step_r;
                for (int i = 0; i < 3; i++) begin
                    row_e[i] <= row_e[i] + dy_r[i];
                    e_p0[i]  <= row_e[i] + dy_r[i];
                end
            end else begin
                x_p0    <= x_p0 + VW'(1);
                addr_p0 <= addr_p0 + FAW'(1);
                for (int i = 0; i < 3; i++) e_p0[i] <= e_p0[i] + dx_r[i];
            end
        end
    end

    // Stage p1: fragment output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            y_p1    <= '0;
            addr_p1 <= '0;
        end else if (!vld_p1 || frag_ready) begin
            vld_p1 <= advance && covered_p0;
            if (advance && covered_p0) begin
                x_p1    <= x_p0;
                y_p1    <= y_p0;
                addr_p1 <= addr_p0;
            end
        end
    end

    assign frag_valid = vld_p1;
    assign frag_x     = x_p1;
    assign frag_y     = y_p1;
    assign frag_addr  = addr_p1;

endmodule

// File: tb/tb_tiled_rasterizer.sv
// Directed bench for tiled_rasterizer on a 16x16 framebuffer, culling and non-culling.
module tb_tiled_rasterizer;

    typedef logic [40:0] frag_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [11:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic start_a = 1'b0, start_nc = 1'b0;
    logic frag_ready = 1'b1;

    logic ready_a, valid_a, done_a;
    logic signed [11:0] fx_a, fy_a;
    logic [16:0] faddr_a;
    logic ready_nc, valid_nc, done_nc;
    logic signed [11:0] fx_nc, fy_nc;
    logic [16:0] faddr_nc;

    int checks = 0;
    int errors = 0;

    frag_t q_a[$];
    frag_t q_nc[$];
    frag_t exp_q[$];
    frag_t exp30[$];
    int done_cnt_a = 0, done_cnt_nc = 0;
    int stall_cnt = 0, stall_bad = 0;
    logic  stall_prev = 1'b0;
    frag_t prev_frag = '0;

    always #5 clk = ~clk;

    tiled_rasterizer #(.FB_WIDTH(16), .FB_HEIGHT(16), .CULL_BACK(1)) dut (
        .clk(clk), .rst(rst),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .start(start_a), .ready(ready_a),
        .frag_valid(valid_a), .frag_ready(frag_ready),
        .frag_x(fx_a), .frag_y(fy_a), .frag_addr(faddr_a),
        .done(done_a)
    );

    tiled_rasterizer #(.FB_WIDTH(16), .FB_HEIGHT(16), .CULL_BACK(0)) dut_nc (
        .clk(clk), .rst(rst),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .start(start_nc), .ready(ready_nc),
        .frag_valid(valid_nc), .frag_ready(frag_ready),
        .frag_x(fx_nc), .frag_y(fy_nc), .frag_addr(faddr_nc),
        .done(done_nc)
    );

    // Fragment/done monitors and output-stability watch during stalls.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_a && frag_ready) q_a.push_back({fx_a, fy_a, faddr_a});
            if (done_a) done_cnt_a++;
            if (stall_prev) begin
                stall_cnt++;
                if (!valid_a || ({fx_a, fy_a, faddr_a} != prev_frag)) stall_bad++;
            end
            stall_prev = valid_a && !frag_ready;
            prev_frag  = {fx_a, fy_a, faddr_a};
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (valid_nc && frag_ready) q_nc.push_back({fx_nc, fy_nc, faddr_nc});
            if (done_nc) done_cnt_nc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint edge_ref(int px, int py, int xa, int ya, int xb, int yb);
        return longint'((px - xa) * (yb - ya) - (py - ya) * (xb - xa));
    endfunction

    // Direct-evaluation reference: every pixel of the 16x16 framebuffer, row-major.
    function automatic void ref_frags(int ax, int ay, int bx, int by, int cx, int cy, bit cull);
        longint area, e0, e1, e2;
        exp_q.delete();
        area = edge_ref(cx, cy, ax, ay, bx, by);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                e0 = edge_ref(x, y, ax, ay, bx, by);
                e1 = edge_ref(x, y, bx, by, cx, cy);
                e2 = edge_ref(x, y, cx, cy, ax, ay);
                if ((area > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                    (area < 0 && !cull && e0 <= 0 && e1 <= 0 && e2 <= 0))
                    exp_q.push_back({12'(x), 12'(y), 17'(y * 16 + x)});
            end
        end
    endfunction

    task automatic launch(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input bit nc);
        x0 = 12'(ax); y0 = 12'(ay);
        x1 = 12'(bx); y1 = 12'(by);
        x2 = 12'(cx); y2 = 12'(cy);
        if (nc) start_nc = 1'b1;
        else    start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        start_nc = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit nc, input int dbase,
                             input int bound, input bit rnd);
        int n = 0;
        while ((nc ? done_cnt_nc : done_cnt_a) == dbase && n < bound) begin
            if (rnd) frag_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        frag_ready = 1'b1;
        check({tag, " done seen before timeout"}, longint'(n < bound), 1);
        repeat (3) tick();
        check({tag, " done pulses"}, (nc ? done_cnt_nc : done_cnt_a) - dbase, 1);
    endtask

    task automatic cmp_frags(input string tag, input bit nc, input int base);
        int n;
        frag_t g;
        n = (nc ? q_nc.size() : q_a.size()) - base;
        check({tag, " fragment count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            g = nc ? q_nc[base + i] : q_a[base + i];
            check($sformatf("%s frag[%0d]", tag, i), longint'(g), longint'(exp_q[i]));
        end
    endtask

    initial begin
        int base, dbase, n, inrange;
        frag_t g;

        // Reset state
        repeat (3) tick();
        check("reset ready", ready_a, 1);
        check("reset frag_valid", valid_a, 0);
        check("reset done", done_a, 0);
        check("reset frag_x", fx_a, 0);
        check("reset frag_y", fy_a, 0);
        check("reset frag_addr", faddr_a, 0);
        rst = 1'b1;
        tick();

        // Front-facing triangle x+y<=4, timing and fragment list
        ref_frags(0, 0, 0, 4, 4, 0, 1'b1);
        exp30 = exp_q;
        check("t30 model count", exp30.size(), 15);
        base = q_a.size(); dbase = done_cnt_a;
        launch(0, 0, 0, 4, 4, 0, 1'b0);
        check("t30 ready low in SETUP", ready_a, 0);
        tick();
        check("t30 no fragment at N+2", valid_a, 0);
        tick();
        check("t30 valid at N+3", valid_a, 1);
        check("t30 first x", fx_a, 0);
        check("t30 first y", fy_a, 0);
        check("t30 first addr", faddr_a, 0);
        wait_done("t30", 1'b0, dbase, 100, 1'b0);
        cmp_frags("t30", 1'b0, base);
        check("t30 total", q_a.size() - base, 15);
        if (q_a.size() - base == 15) begin
            g = q_a[base + 14];
            check("t30 last addr", g[16:0], 64);
            check("t30 last y", g[28:17], 4);
        end

        // Back-facing winding is culled: done at N+2, ready at N+3
        base = q_a.size(); dbase = done_cnt_a;
        launch(0, 0, 4, 0, 0, 4, 1'b0);
        check("t31 done low at N+1", done_a, 0);
        tick();
        check("t31 done at N+2", done_a, 1);
        tick();
        check("t31 done one cycle", done_a, 0);
        check("t31 ready at N+3", ready_a, 1);
        repeat (3) tick();
        check("t31 culled fragments", q_a.size() - base, 0);
        check("t31 done pulses", done_cnt_a - dbase, 1);

        // Same winding with culling disabled
        exp_q = exp30;
        base = q_nc.size(); dbase = done_cnt_nc;
        launch(0, 0, 4, 0, 0, 4, 1'b1);
        wait_done("t31nc", 1'b1, dbase, 100, 1'b0);
        cmp_frags("t31nc", 1'b1, base);

        // Triangle entirely off-tile: empty bbox
        base = q_a.size(); dbase = done_cnt_a;
        launch(-20, -20, -10, -20, -20, -10, 1'b0);
        check("t32 ready low in SETUP", ready_a, 0);
        tick();
        check("t32 done at N+2", done_a, 1);
        check("t32 valid low", valid_a, 0);
        tick();
        check("t32 ready at N+3", ready_a, 1);
        repeat (3) tick();
        check("t32 fragments", q_a.size() - base, 0);

        // Random backpressure: same sequence, stable outputs while stalled
        exp_q = exp30;
        base = q_a.size(); dbase = done_cnt_a;
        n = stall_cnt;
        launch(0, 0, 0, 4, 4, 0, 1'b0);
        wait_done("t33", 1'b0, dbase, 500, 1'b1);
        cmp_frags("t33", 1'b0, base);
        check("t33 stalls exercised", longint'(stall_cnt > n), 1);
        check("t33 unstable during stall", stall_bad, 0);

        // Large triangle clipped to the tile
        ref_frags(0, 0, 0, 40, 40, 0, 1'b1);
        base = q_a.size(); dbase = done_cnt_a;
        launch(0, 0, 0, 40, 40, 0, 1'b0);
        wait_done("t34", 1'b0, dbase, 2000, 1'b0);
        cmp_frags("t34", 1'b0, base);
        inrange = 1;
        for (int i = base; i < q_a.size(); i++) begin
            g = q_a[i];
            if ($signed(g[40:29]) < 0 || $signed(g[40:29]) > 15 ||
                $signed(g[28:17]) < 0 || $signed(g[28:17]) > 15) inrange = 0;
        end
        check("t34 fragments in tile", inrange, 1);
        check("t34 count", q_a.size() - base, 256);

        // Reset during scan, then a fresh triangle
        base = q_a.size(); dbase = done_cnt_a;
        launch(0, 0, 0, 4, 4, 0, 1'b0);
        n = 0;
        while (q_a.size() - base < 5 && n < 50) begin
            tick();
            n++;
        end
        check("t35 reached fifth fragment", longint'(n < 50), 1);
        rst = 1'b0;
        tick();
        check("t35 valid cleared", valid_a, 0);
        check("t35 done low", done_a, 0);
        check("t35 ready after reset", ready_a, 1);
        check("t35 frag_addr cleared", faddr_a, 0);
        rst = 1'b1;
        repeat (20) tick();
        check("t35 aborted fragments", q_a.size() - base, 5);
        check("t35 no stale done", done_cnt_a - dbase, 0);
        exp_q = exp30;
        base = q_a.size(); dbase = done_cnt_a;
        launch(0, 0, 0, 4, 4, 0, 1'b0);
        wait_done("t35 new", 1'b0, dbase, 100, 1'b0);
        cmp_frags("t35 new", 1'b0, base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiled_rasterizer.md
TILED_RASTERIZER -- requirements
Module: tiled_rasterizer

Interface
REQ-001 SHALL have parameter VERTEX_WIDTH, default 12: signed vertex coordinate width.
REQ-002 SHALL have parameter FB_ADDR_WIDTH, default 17: framebuffer address width.
REQ-003 SHALL have parameters FB_WIDTH/FB_HEIGHT, defaults 320/240: framebuffer size, used for address stride.
REQ-004 SHALL have parameters TILE_MIN_X/TILE_MAX_X/TILE_MIN_Y/TILE_MAX_Y, defaults 0/FB_WIDTH-1/0/FB_HEIGHT-1: inclusive clip tile.
REQ-005 SHALL have parameter CULL_BACK, default 1: 1 drops negative-area triangles, 0 rasterises both windings.
REQ-006 SHALL have ports clk in 1 (sole clock, rising edge) and rst in 1 (synchronous, active-low reset).
REQ-007 SHALL have ports x0,y0,x1,y1,x2,y2 in VERTEX_WIDTH signed: vertices, sampled only on start handshake.
REQ-008 SHALL have ports start in 1 and ready out 1: triangle accept handshake.
REQ-009 SHALL have ports frag_valid out 1 and frag_ready in 1: fragment stream handshake.
REQ-010 SHALL have ports frag_x/frag_y out VERTEX_WIDTH and frag_addr out FB_ADDR_WIDTH: covered pixel and its address.
REQ-011 SHALL have port done out 1: one-cycle pulse at triangle completion.

Function
REQ-012 SHALL implement states IDLE, SETUP, SCAN, DONE; ready=1 only in IDLE.
REQ-013 SHALL latch vertices on start&&ready (cycle N), SETUP in N+1, and start SCAN in N+2.
REQ-014 SETUP SHALL compute the bbox clipped to the tile, plus edge coefficients and area via sub-module.
REQ-015 Edge i (v0->v1, v1->v2, v2->v0) SHALL be E(x,y)=(x-xa)*(yb-ya)-(y-ya)*(xb-xa), width 2*VERTEX_WIDTH+2 signed; area=E0(v2).
REQ-016 Pixel SHALL be covered iff all E>=0 (area>0), or all E<=0 (area<0 and CULL_BACK=0); edges are inclusive.
REQ-017 If the bbox is empty, area==0, or area<0 with CULL_BACK=1, SETUP SHALL go to DONE with zero fragments.
REQ-018 SCAN SHALL evaluate one pixel per clock, row-major, x increasing then y increasing, starting (min_x,min_y).
REQ-019 Edge values SHALL update incrementally: x step adds dE/dx; new row reloads row-start value plus dE/dy; no per-pixel multiply.
REQ-020 frag_addr SHALL equal y*FB_WIDTH+x, maintained incrementally (+1 per x, +FB_WIDTH-(max_x-min_x) per row).
REQ-021 A covered pixel SHALL be registered to the output one cycle after evaluation; first fragment at N+3 when covered and frag_ready=1.
REQ-022 While frag_valid&&!frag_ready, frag_x/frag_y/frag_addr SHALL hold stable and scanning SHALL stall; no fragment lost or duplicated.
REQ-023 With frag_ready held high, throughput SHALL be one pixel per clock.
REQ-024 After the last bbox pixel is evaluated and the output register drains, the FSM SHALL enter DONE.
REQ-025 DONE SHALL pulse done for exactly one cycle, then return to IDLE; start in DONE is ignored.

Reset
REQ-026 When rst=0 at a clock edge: state=IDLE, ready=1 next cycle, frag_valid=0, done=0, frag_x/y/addr=0.
REQ-027 Reset mid-SCAN SHALL abort the triangle immediately with no further fragments or done pulse.

Structure
REQ-028 State enum and edge-width localparam SHALL live in shared package raster_pkg.
REQ-029 Bbox clipping and edge/area setup SHALL be sub-module tri_setup (combinational or one register stage inside the SETUP cycle).

Verification (FB 16x16, full tile, CULL_BACK=1)
REQ-030 (0,0),(0,4),(4,0), frag_ready=1: exactly 15 fragments (x+y<=4), first addr 0 at N+3, last (0,4) addr 64, one done.
REQ-031 Same triangle wound (0,0),(4,0),(0,4): zero fragments, done at N+2; with CULL_BACK=0, same 15 fragments as REQ-030.
REQ-032 (-20,-20),(-10,-20),(-20,-10): bbox empty, zero fragments, done at N+2, ready back at N+3.
REQ-033 Triangle of REQ-030 with frag_ready toggled pseudo-randomly: identical 15-fragment sequence, outputs stable during stall.
REQ-034 (0,0),(0,40),(40,0): all fragments within 0..15 in x and y; fragment count equals the count from a reference model.
REQ-035 rst=0 on the 5th fragment, then a new start: no stale fragment or done from the aborted triangle, and the new triangle completes correctly.
